// File: rtl/core_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the core <-> memory-controller bridge:
//   state_e      : run-control states of the bridge
//   CMD_OP_BIT   : position of the op bit inside the core command
//   CMD_ADDR_MSB : top bit of the address/len field (also top of tuser addr)
// -----------------------------------------------------------------------------
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int CMD_OP_BIT(input int cmd_width);
        return cmd_width - 1;
    endfunction

    function automatic int CMD_ADDR_MSB(input int tuser_width);
        return tuser_width - 2;
    endfunction

endpackage

// File: rtl/core_rd_fifo.sv
// -----------------------------------------------------------------------------
// core_rd_fifo
// Synchronous read-data buffer with registered storage and pointers.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_data_i    write one entry (ignored when full)
//   pop_i                  drop the head entry (ignored when empty)
//   full_o, empty_o        occupancy flags decoded from registered pointers
//   head_o                 current head entry (undefined content when empty)
// -----------------------------------------------------------------------------
module core_rd_fifo #(
    parameter int DATA_WIDTH    = 1024,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int AW = $clog2(RD_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [RD_FIFO_DEPTH];
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s  = push_i && !full_s;
    assign pop_s   = pop_i && !empty_s;

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate validity.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/core_ctrl_bridge.sv
// -----------------------------------------------------------------------------
// core_ctrl_bridge
// ap_ctrl_chain controlled bridge between a compute core and the AXI-Stream
// memory-controller ports. A run accepts a programmed number of read beats,
// buffers them for the core, and then holds ap_done until ap_continue.
// Ports:
//   ap_clk/ap_rst_n             clock, asynchronous active-low reset
//   ap_start/ap_continue        run request / done acknowledge
//   ap_idle/ap_ready/ap_done    run status
//   i_num_reads                 read beats expected, sampled at start
//   o_controller_ready, i_command_valid, i_command, i_write_data
//                               core command path (passed through in BUSY)
//   o_read_data_valid, i_read_data_ready, o_read_data
//                               buffered read data towards the core
//   m_axis_wr_*                 command/write-data stream to the controller
//   s_axis_rd_*                 read-data stream from the controller
// -----------------------------------------------------------------------------
module core_ctrl_bridge
    import core_ctrl_pkg::*;
#(
    parameter int TUSER_WIDTH   = 23,
    parameter int DATA_WIDTH    = 1024,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ap_start,
    input  logic                      ap_continue,
    output logic                      ap_idle,
    output logic                      ap_ready,
    output logic                      ap_done,
    input  logic [CNT_WIDTH-1:0]      i_num_reads,
    output logic                      o_controller_ready,
    input  logic                      i_command_valid,
    input  logic [TUSER_WIDTH+1:0]    i_command,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    output logic                      o_read_data_valid,
    input  logic                      i_read_data_ready,
    output logic [DATA_WIDTH-1:0]     o_read_data,
    output logic                      m_axis_wr_tvalid,
    input  logic                      m_axis_wr_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_wr_tdata,
    output logic [TUSER_WIDTH-1:0]    m_axis_wr_tuser,
    output logic [DATA_WIDTH/8-1:0]   m_axis_wr_tkeep,
    output logic                      m_axis_wr_tlast,
    input  logic                      s_axis_rd_tvalid,
    output logic                      s_axis_rd_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_rd_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_rd_tkeep,
    input  logic                      s_axis_rd_tlast
);

    localparam int CMD_WIDTH = TUSER_WIDTH + 2;
    localparam int OP_BIT    = CMD_OP_BIT(CMD_WIDTH);
    localparam int ADDR_MSB  = CMD_ADDR_MSB(TUSER_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q;
    state_e                state_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q;
    logic [CNT_WIDTH-1:0]  rd_cnt_d;
    logic [CNT_WIDTH-1:0]  target_q;
    logic [CNT_WIDTH-1:0]  target_d;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;
    logic                  ap_idle_q;
    logic                  ap_done_q;
    logic                  busy_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  rd_hs_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] fifo_head_s;
    logic                  unused_s;

    // Reserved command bits and the ignored read-side tkeep/tlast.
    assign unused_s = ^{i_command[CMD_WIDTH-2:ADDR_MSB+1], s_axis_rd_tkeep, s_axis_rd_tlast};

    assign busy_s    = (state_q == BUSY);
    // Ready comes only from registered fullness: a pop cannot reopen it this cycle.
    assign s_axis_rd_tready  = busy_s && !fifo_full_s;
    assign rd_hs_s           = s_axis_rd_tvalid && s_axis_rd_tready;
    assign o_read_data_valid = !fifo_empty_s;
    assign pop_s             = o_read_data_valid && i_read_data_ready;
    assign o_read_data       = o_read_data_valid ? fifo_head_s : {DATA_WIDTH{1'b0}};
    assign cnt_inc_s         = rd_cnt_q + CNT_ONE;

    assign ap_idle  = ap_idle_q;
    assign ap_done  = ap_done_q;
    assign ap_ready = ap_rst_n && ap_idle_q && ap_start;

    core_rd_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .RD_FIFO_DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .push_i      (rd_hs_s),
        .push_data_i (s_axis_rd_tdata),
        .pop_i       (pop_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .head_o      (fifo_head_s)
    );

    // Run-control next state, beat counter and target latch.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    target_d = i_num_reads;
                    rd_cnt_d = {CNT_WIDTH{1'b0}};
                    state_d  = (i_num_reads == {CNT_WIDTH{1'b0}}) ? DRAIN : BUSY;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (rd_hs_s) begin
                    rd_cnt_d = (rd_cnt_q == target_q) ? rd_cnt_q : cnt_inc_s;
                    state_d  = (cnt_inc_s == target_q) ? DRAIN : BUSY;
                end else begin
                    state_d  = BUSY;
                end
            end
            DRAIN: begin
                if (fifo_empty_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                // A start seen together with continue is taken next cycle from IDLE.
                if (ap_continue) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM registers with registered idle/done status.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            rd_cnt_q  <= {CNT_WIDTH{1'b0}};
            target_q  <= {CNT_WIDTH{1'b0}};
            ap_idle_q <= 1'b1;
            ap_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            target_q  <= target_d;
            ap_idle_q <= (state_d == IDLE);
            ap_done_q <= (state_d == DONE);
        end
    end

    // Zero-latency command pass-through, active only while a run is in BUSY.
    always_comb begin
        m_axis_wr_tkeep = {(DATA_WIDTH/8){1'b1}};
        m_axis_wr_tlast = 1'b0;
        if (busy_s) begin
            m_axis_wr_tvalid   = i_command_valid;
            o_controller_ready = m_axis_wr_tready;
            m_axis_wr_tdata    = i_write_data;
            m_axis_wr_tuser    = {i_command[OP_BIT], i_command[ADDR_MSB:0]};
        end else begin
            m_axis_wr_tvalid   = 1'b0;
            o_controller_ready = 1'b0;
            m_axis_wr_tdata    = {DATA_WIDTH{1'b0}};
            m_axis_wr_tuser    = {TUSER_WIDTH{1'b0}};
        end
    end

endmodule
